// File: rtl/irrigation_scheduler.sv
// Round-robin irrigation scheduler: one shared pump, NUM_ZONES valves, tank-gated.
// Optional pause support is compiled in with `define IRR_PAUSE_EN.
module irrigation_scheduler #(
  parameter int NUM_ZONES    = 4,
  parameter int WATER_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 8,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_ZONES-1:0]         req,
  input  logic                         tank_ok,
  input  logic                         pump_ack,
  input  logic                         fault_clr,
`ifdef IRR_PAUSE_EN
  input  logic                         pause,
`endif
  output logic [NUM_ZONES-1:0]         valve,
  output logic                         pump_on,
  output logic [$clog2(NUM_ZONES)-1:0] active_zone,
  output logic                         busy,
  output logic                         zone_done,
  output logic [1:0]                   err,
  output logic [2:0]                   dbg_state
);
  localparam int ZW    = $clog2(NUM_ZONES);
  localparam int MAX_A = (WATER_CYCLES > ACK_TIMEOUT) ? WATER_CYCLES : ACK_TIMEOUT;
  localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int TW    = $clog2(MAX_C) + 1;

  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] WATER_LAST = TW'(WATER_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    WATER = 3'd2,
    CLOSE = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [ZW-1:0]        last, last_n, zone_n, pick, idx;
  logic                 found;
  logic [1:0]           err_n;
  logic                 done_n, drive_n, pump_n, busy_n;
  logic [NUM_ZONES-1:0] valve_n;
`ifdef IRR_PAUSE_EN
  logic                 paused, paused_n, resume, resume_n;
  logic [TW-1:0]        shadow, shadow_n;
`endif

  assign dbg_state = state;

  // Requests are levels: a zone is granted when its bit is high while IDLE with
  // tank_ok; the grant then runs to completion regardless of the request.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_ZONES; i++) begin
      idx = ZW'((int'(last) + i) % NUM_ZONES);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    zone_n  = active_zone;
    last_n  = last;
    err_n   = err;
    done_n  = 1'b0;
`ifdef IRR_PAUSE_EN
    paused_n = 1'b0;
    resume_n = resume;
    shadow_n = shadow;
`endif
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (found && tank_ok) begin
          state_n = OPEN;
          zone_n  = pick;
        end
      end
      OPEN: begin
        if (!tank_ok) begin
          state_n = FAULT;
          err_n   = 2'b11;
        end else if (pump_ack) begin
          state_n = WATER;
        end else if (timer == ACK_LAST) begin
          state_n = FAULT;
          err_n   = 2'b01;
        end
      end
      WATER: begin
        if (!tank_ok) begin
          state_n = FAULT;
          err_n   = 2'b11;
`ifdef IRR_PAUSE_EN
        end else if (pause) begin
          timer_n  = timer;
          paused_n = 1'b1;
        end else if (paused) begin
          state_n  = OPEN;
          resume_n = 1'b1;
          shadow_n = timer;
`endif
        end else if (!pump_ack) begin
          state_n = FAULT;
          err_n   = 2'b01;
        end else if (timer == WATER_LAST) begin
          state_n = CLOSE;
          done_n  = 1'b1;
          last_n  = active_zone;
        end
      end
      CLOSE: begin
        if (timer == GAP_LAST) state_n = IDLE;
      end
      FAULT: begin
        timer_n = '0;
        if (fault_clr) begin
          state_n = IDLE;
          err_n   = 2'b00;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) timer_n = '0;
`ifdef IRR_PAUSE_EN
    // Returning from a pause re-confirms pressure, then picks up the saved count.
    if (state == OPEN && state_n == WATER && resume) begin
      timer_n  = shadow;
      resume_n = 1'b0;
    end
    if (state_n == IDLE || state_n == FAULT) resume_n = 1'b0;
`endif

    drive_n = (state_n == OPEN) || (state_n == WATER);
`ifdef IRR_PAUSE_EN
    if (paused_n) drive_n = 1'b0;
`endif
    valve_n = '0;
    if (drive_n) valve_n[zone_n] = 1'b1;
    pump_n = drive_n;
    busy_n = (state_n == OPEN) || (state_n == WATER) || (state_n == CLOSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      last        <= ZW'(NUM_ZONES - 1);
      active_zone <= '0;
      valve       <= '0;
      pump_on     <= 1'b0;
      busy        <= 1'b0;
      zone_done   <= 1'b0;
      err         <= 2'b00;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      last        <= last_n;
      active_zone <= zone_n;
      valve       <= valve_n;
      pump_on     <= pump_n;
      busy        <= busy_n;
      zone_done   <= done_n;
      err         <= err_n;
    end
  end

`ifdef IRR_PAUSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paused <= 1'b0;
      resume <= 1'b0;
      shadow <= '0;
    end else begin
      paused <= paused_n;
      resume <= resume_n;
      shadow <= shadow_n;
    end
  end
`endif
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: directed scenarios plus randomized
// grants, predicted from round-robin order and cycle arithmetic.
module tb_irrigation_scheduler;
  localparam int N   = 4;
  localparam int WC  = 16;
  localparam int AT  = 8;
  localparam int GAP = 2;
  localparam int W   = 38;

  logic         clk, reset;
  logic [N-1:0] req;
  logic         tank_ok, pump_ack, fault_clr;
  logic [N-1:0] valve;
  logic         pump_on, busy, zone_done;
  logic [1:0]   active_zone, err;
  logic [2:0]   dbg_state;

  irrigation_scheduler #(
    .NUM_ZONES(N), .WATER_CYCLES(WC), .ACK_TIMEOUT(AT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .tank_ok(tank_ok), .pump_ack(pump_ack),
    .fault_clr(fault_clr), .valve(valve), .pump_on(pump_on),
    .active_zone(active_zone), .busy(busy), .zone_done(zone_done), .err(err),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int model_last = N - 1;

  // pump model: reports pressure ack_delay cycles after pump_on rises
  int ack_delay = 0;
  bit ack_stuck = 0;
  bit ack_kill  = 0;
  int on_cnt    = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input int zone, input int e, input int start, input int ev);
    return {4'(zone), 2'(e), 16'(start), 16'(ev)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int z;
    for (int i = 1; i <= N; i++) begin
      z = (last + i) % N;
      if (((r >> z) & 1) != 0) return z;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
    pump_ack = pump_on && !ack_stuck && !ack_kill && (on_cnt >= ack_delay);
    on_cnt   = pump_on ? on_cnt + 1 : 0;
  endtask

  task automatic finish_grant(input int e);
    int n;
    if (e != 0) begin
      n   = $urandom_range(0, 3);
      req = N'($urandom_range(1, 2**N - 1));
      repeat (n) begin
        tick();
        check("fault_err_held", err, e);
        check("fault_busy_low", busy, 0);
      end
      req       = '0;
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("fault_cleared", err, 0);
    end else begin
      n = 0;
      while (busy && n < 20) begin
        tick();
        n++;
      end
      check("idle_after_gap", n, GAP);
    end
  endtask

  // kind: 0 normal, 1 ack never comes, 2 tank drop in WATER, 3 ack drop in WATER
  task automatic run_grant(input logic [N-1:0] r, input int d, input int kind, input int k);
    int zone, s, ev, e, hit_cyc, n;
    bit seen;
    zone    = rr_pick(r, model_last);
    s       = cyc + 1;
    hit_cyc = s + d + 1 + k;
    case (kind)
      1:       begin ev = s + AT;          e = 1; end
      2:       begin ev = hit_cyc + 1;     e = 3; end
      3:       begin ev = hit_cyc + 1;     e = 1; end
      default: begin ev = s + d + 1 + WC;  e = 0; end
    endcase
    if (e == 0) model_last = zone;
    exp_q.push_back(mk(zone, e, s, ev));
    req       = r;
    ack_delay = d;
    ack_stuck = (kind == 1);
    seen      = 0;
    n         = 0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (cyc == hit_cyc) begin
        if (kind == 2) tank_ok = 1'b0;
        if (kind == 3) begin
          ack_kill = 1'b1;
          pump_ack = 1'b0;
        end
        if (kind == 0) req = N'($urandom_range(0, 2**N - 1));
      end
      if (zone_done || err != 2'b00) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: zone %0d got no completion or fault in %0d cycles, required one", zone, n);
    end
    req       = '0;
    tank_ok   = 1'b1;
    ack_kill  = 0;
    ack_stuck = 0;
    finish_grant(e);
  endtask

  // back-to-back grants with req held; drop bits are cleared during the first WATER
  task automatic run_chain(input logic [N-1:0] r, input int nn, input int d, input logic [N-1:0] drop);
    int s, zone, done_cnt, n, drop_cyc;
    logic [N-1:0] rr;
    s        = cyc + 1;
    drop_cyc = s + d + 1 + 5;
    for (int i = 0; i < nn; i++) begin
      rr         = (i == 0) ? r : (r & ~drop);
      zone       = rr_pick(rr, model_last);
      model_last = zone;
      exp_q.push_back(mk(zone, 0, s, s + d + 1 + WC));
      s = s + d + 1 + WC + GAP + 1;
    end
    req       = r;
    ack_delay = d;
    done_cnt  = 0;
    n         = 0;
    while (done_cnt < nn && n < nn * 60) begin
      tick();
      n++;
      if (cyc == drop_cyc) req = r & ~drop;
      if (zone_done) done_cnt++;
    end
    if (done_cnt < nn) begin
      checks++;
      errors++;
      $display("FAIL chain_timeout: got %0d completions, required %0d", done_cnt, nn);
    end
    req = '0;
    finish_grant(0);
  endtask

  // scoreboard monitor
  logic [N-1:0] prev_valve = '0;
  logic [1:0]   prev_err   = '0;
  logic [W-1:0] f;
  always @(negedge clk) begin
    if (reset) begin
      prev_valve <= '0;
      prev_err   <= '0;
    end else begin
      check("valve_onehot0", 32'($onehot0(valve)), 1);
      check("pump_matches_valve", pump_on, valve != '0);
      if (valve != '0 && prev_valve == '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: valve %0h opened, required no grant", valve);
        end else begin
          f = exp_q[0];
          check("grant_valve", valve, 1 << f[37:34]);
          check("grant_cycle", cyc[15:0], f[31:16]);
        end
      end
      if (zone_done || (err != 2'b00 && prev_err == 2'b00)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: zone_done %0b err %0b, required none", zone_done, err);
        end else begin
          f = exp_q.pop_front();
          check("event_err", err, f[33:32]);
          check("event_cycle", cyc[15:0], f[15:0]);
          check("done_only_on_success", zone_done, f[33:32] == 2'b00);
          if (f[33:32] == 2'b00) check("done_zone", active_zone, f[37:34]);
          else check("fault_valve_off", valve, 0);
        end
      end
      prev_valve <= valve;
      prev_err   <= err;
    end
  end

  // main sequence
  initial begin
    int s, zone;
    logic [N-1:0] r;
    reset     = 1'b1;
    req       = '0;
    tank_ok   = 1'b1;
    pump_ack  = 1'b0;
    fault_clr = 1'b0;
    tick();
    tick();
    check("reset_valve", valve, 0);
    check("reset_pump", pump_on, 0);
    check("reset_busy", busy, 0);
    check("reset_done", zone_done, 0);
    check("reset_err", err, 0);
    check("reset_zone", active_zone, 0);
    reset = 1'b0;

    run_chain(4'b1111, 5, 0, 4'b0000);       // order 0,1,2,3,0
    run_grant(4'b0001, 1, 0, 3);
    run_chain(4'b1010, 2, 1, 4'b0010);       // zone 1 completes despite drop, then 3
    run_grant(4'b0100, 0, 1, 0);             // pump never acks
    run_grant(4'b0100, 0, 0, 0);
    run_grant(4'b0010, AT - 1, 0, 2);        // ack on the last permitted OPEN cycle
    run_grant(4'b1000, 2, 2, 5);             // tank drops in WATER
    run_grant(4'b0001, 0, 3, 9);             // pressure lost in WATER

    tank_ok = 1'b0;
    req     = 4'b1111;
    repeat (8) begin
      tick();
      check("tank_low_no_grant", busy, 0);
      check("tank_low_no_err", err, 0);
    end
    req     = '0;
    tank_ok = 1'b1;
    tick();

    for (int t = 0; t < 24; t++) begin
      int kind, d, sel;
      r   = N'($urandom_range(1, 2**N - 1));
      d   = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      kind = (sel <= 5) ? 0 : (sel == 6) ? 1 : (sel == 7) ? 2 : (sel == 8) ? 3 : 0;
      if (sel == 9) d = AT - 1;
      run_grant(r, d, kind, $urandom_range(0, WC - 2));
    end

    // async reset in the middle of WATER
    r         = 4'b0110;
    zone      = rr_pick(r, model_last);
    s         = cyc + 1;
    exp_q.push_back(mk(zone, 0, s, s + 2 + WC));
    req       = r;
    ack_delay = 1;
    for (int n = 0; n < 40 && cyc != s + 2 + 5; n++) tick();
    #2 reset = 1'b1;
    #1;
    check("async_reset_valve", valve, 0);
    check("async_reset_pump", pump_on, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_err", err, 0);
    check("async_reset_zone", active_zone, 0);
    exp_q.delete();
    model_last = N - 1;
    req        = '0;
    tick();
    tick();
    reset = 1'b0;
    run_grant(4'b1111, 0, 0, 3);             // zone 0 first again

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
